// File: rtl/fp_accum_seq.sv
// Floating-point reduction sequencer: folds LEN operands into one sum through a
// single shared combinational add/subtract unit, with valid/ready on both sides.

module fpaddsub_32b #(
  parameter int M = 8,
  parameter int N = 23
) (
  input  logic [M+N:0] a_in,
  input  logic [M+N:0] b_in,
  input  logic         sub,
  output logic [M+N:0] result
);
  localparam int W   = M + N + 1;
  localparam int MW  = N + 4;
  localparam int LZW = $clog2(MW + 1);

  logic [W-2:0]   a_mag, b_mag;
  logic           swap, sx, sy, found;
  logic [M-1:0]   ex, ey, diff, e_out;
  logic [MW-1:0]  mx, my, my_sh, m_norm;
  logic [MW:0]    sum;
  logic [LZW-1:0] lz;
  logic [3:0]     unused_bits;

  // Larger magnitude always on the x side so the aligned difference never goes negative.
  always_comb begin
    a_mag = a_in[W-2:0];
    b_mag = b_in[W-2:0];
    swap  = b_mag > a_mag;
    sx    = swap ? (b_in[W-1] ^ sub) : a_in[W-1];
    sy    = swap ? a_in[W-1] : (b_in[W-1] ^ sub);
    ex    = swap ? b_in[W-2:N] : a_in[W-2:N];
    ey    = swap ? a_in[W-2:N] : b_in[W-2:N];
    mx    = {1'b1, (swap ? b_in[N-1:0] : a_in[N-1:0]), 3'b000};
    my    = {1'b1, (swap ? a_in[N-1:0] : b_in[N-1:0]), 3'b000};
    diff  = ex - ey;
    my_sh = (int'(diff) >= MW) ? '0 : (my >> diff);
    sum   = (sx == sy) ? ({1'b0, mx} + {1'b0, my_sh}) : ({1'b0, mx} - {1'b0, my_sh});

    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (!found && sum[MW-1-i]) begin
        lz    = LZW'(i);
        found = 1'b1;
      end
    end

    if (sum[MW]) begin
      m_norm = sum[MW:1];
      e_out  = ex + M'(1);
    end else begin
      m_norm = sum[MW-1:0] << lz;
      e_out  = ex - M'(lz);
    end

    result      = (found || sum[MW]) ? {sx, e_out, m_norm[MW-2:3]} : '0;
    unused_bits = {m_norm[MW-1], m_norm[2:0]};
  end
endmodule

module fp_accum_seq #(
  parameter int M     = 8,
  parameter int N     = 23,
  parameter int LEN   = 9,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M+N:0] in_data,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M+N:0] out_data,
  output logic         busy
);
  localparam int W = M + N + 1;

  typedef enum logic [1:0] {IDLE, FIRST, ACCUM, DONE} state_t;

  state_t           state, state_nx;
  logic [W-1:0]     acc, acc_nx, out_data_nx, sum;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             out_valid_nx, accept, last;

  fpaddsub_32b #(.M(M), .N(N)) u_add (
    .a_in  (acc),
    .b_in  (in_data),
    .sub   (in_sub),
    .result(sum)
  );

  assign in_ready = (state == FIRST) || (state == ACCUM);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CNT_W'(LEN - 1));

  always_comb begin
    state_nx    = state;
    acc_nx      = acc;
    cnt_nx      = cnt;
    out_data_nx = out_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = FIRST;
          cnt_nx   = '0;
        end
      end
      // First operand seeds the accumulator directly; the adder has no +0.0 handling.
      FIRST: begin
        if (accept) begin
          acc_nx = in_data;
          cnt_nx = CNT_W'(1);
          if (LEN == 1) begin
            state_nx    = DONE;
            out_data_nx = in_data;
          end else begin
            state_nx = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nx = sum;
          cnt_nx = cnt + CNT_W'(1);
          if (last) begin
            state_nx    = DONE;
            out_data_nx = sum;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    out_valid_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      out_data  <= out_data_nx;
      out_valid <= out_valid_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (LEN >= 1 && LEN <= (1 << CNT_W) - 1)
        else $error("fp_accum_seq: LEN=%0d does not fit CNT_W=%0d", LEN, CNT_W);
    end
  end
endmodule

// File: tb/tb_fp_accum_seq.sv
// Scoreboard bench for fp_accum_seq: LEN=9 instance for the main flow and a
// LEN=1 instance for the bypass case.

module tb_fp_accum_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, in_ready, in_sub, out_valid, out_ready, busy;
  logic [31:0] in_data, out_data;
  logic        start1, in_valid1, in_ready1, in_sub1, out_valid1, out_ready1, busy1;
  logic [31:0] in_data1, out_data1;

  logic [31:0] exp_q[$];
  int          n_vec   = 0;
  int          n_bad   = 0;
  int          accepts = 0;

  always #5 clk = ~clk;

  fp_accum_seq #(.M(8), .N(23), .LEN(9), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  fp_accum_seq #(.M(8), .N(23), .LEN(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_sub(in_sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .busy(busy1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      accepts = 0;
    end else begin
      if (in_valid && in_ready) accepts++;
      if (out_valid && out_ready) begin
        check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_val("out_data", out_data, exp_q.pop_front());
        check_val("accept_count", 32'(accepts), 32'd9);
        accepts = 0;
      end
    end
  end

  task automatic begin_red(input logic push, input logic [31:0] want);
    if (push) exp_q.push_back(want);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_after_start", 32'(busy), 32'd1);
    check_val("in_ready_first", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] d, input logic s, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = d;
    in_sub   = s;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!in_ready) check_val("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; out_ready = 1'b1;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; in_sub1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_out_data", out_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nine 1.0 back to back
    begin_red(1'b1, 32'h41100000);
    for (int i = 0; i < 9; i++) send(32'h3F800000, 1'b0, 0);
    check_val("latency_out_valid", 32'(out_valid), 32'd1);
    check_val("latency_out_data", out_data, 32'h41100000);
    @(posedge clk); #1;
    check_val("idle_after_out", 32'(busy), 32'd0);

    // 8.0 minus eight 0.5
    begin_red(1'b1, 32'h40800000);
    send(32'h41000000, 1'b0, 0);
    for (int i = 0; i < 8; i++) send(32'h3F000000, 1'b1, 0);
    @(posedge clk); #1;

    // in_sub on the first element is ignored
    begin_red(1'b1, 32'h41100000);
    send(32'h3F800000, 1'b1, 0);
    for (int i = 0; i < 8; i++) send(32'h3F800000, 1'b0, 0);
    @(posedge clk); #1;

    // Gaps, start during ACCUM/DONE, output backpressure
    out_ready = 1'b0;
    begin_red(1'b1, 32'h41100000);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send(32'h3F800000, 1'b0, (i == 0) ? 0 : 2);
    end
    for (int i = 0; i < 5; i++) begin
      check_val("bp_out_valid", 32'(out_valid), 32'd1);
      check_val("bp_out_data", out_data, 32'h41100000);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("done_start_hold", 32'(out_valid), 32'd1);
    start = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("exit_busy", 32'(busy), 32'd0);
    check_val("exit_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_val("no_restart_busy", 32'(busy), 32'd0);
    check_val("no_restart_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Reset after four accepts discards the partial sum
    begin_red(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) send(32'h3F800000, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_out_data", out_data, 32'h0);
    begin_red(1'b1, 32'h41900000);
    for (int i = 0; i < 9; i++) send(32'h40000000, 1'b0, 0);
    @(posedge clk); #1;

    // LEN=1 instance: operand passes straight through
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    in_data1 = 32'hC0400000; in_sub1 = 1'b1; in_valid1 = 1'b1;
    check_val("len1_in_ready", 32'(in_ready1), 32'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check_val("len1_out_valid", 32'(out_valid1), 32'd1);
    check_val("len1_out_data", out_data1, 32'hC0400000);
    @(posedge clk); #1;
    check_val("len1_idle", 32'(busy1), 32'd0);

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
